// File: rtl/store_trace_checker.sv
// Store-trace checker: compares committed data-memory stores, in order, against a
// preloaded table of expected (address, data) pairs and reports a sticky verdict.
module store_trace_checker #(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     memwrite,
  input  logic [31:0]              dataadr,
  input  logic [31:0]              writedata,
  input  logic                     exp_load,
  input  logic [31:0]              exp_adr,
  input  logic [31:0]              exp_data,
  input  logic                     start,
  output logic                     done,
  output logic                     pass,
  output logic                     fail,
  output logic                     timeout,
  output logic                     load_ovf,
  output logic [$clog2(DEPTH)-1:0] err_idx,
  output logic [31:0]              got_adr,
  output logic [31:0]              got_data,
  output logic [$clog2(DEPTH):0]   store_count,
  output logic [15:0]              cycle_count
);

  localparam int          IW      = $clog2(DEPTH);
  localparam int          CW      = IW + 1;
  localparam logic [CW-1:0] FULL  = CW'(DEPTH);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_LOAD, S_RUN, S_PASS, S_FAIL} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] store_count_q, store_count_d;
  logic [15:0]   cycle_count_q, cycle_count_d;
  logic          done_q, done_d, pass_q, pass_d, fail_q, fail_d;
  logic          timeout_q, timeout_d, load_ovf_q, load_ovf_d;
  logic [IW-1:0] err_idx_q, err_idx_d;
  logic [31:0]   got_adr_q, got_adr_d, got_data_q, got_data_d;

  logic [31:0]   tbl_adr  [DEPTH];
  logic [31:0]   tbl_data [DEPTH];
  logic          tbl_we;
  logic          hit, mismatch;

  assign hit = (dataadr   == tbl_adr[store_count_q[IW-1:0]]) &&
               (writedata == tbl_data[store_count_q[IW-1:0]]);

  always_comb begin
    // NOTE: every signal assigned below gets a default here so no path can infer a latch.
    state_d       = state_q;
    count_d       = count_q;
    store_count_d = store_count_q;
    cycle_count_d = cycle_count_q;
    pass_d        = pass_q;
    fail_d        = fail_q;
    timeout_d     = timeout_q;
    load_ovf_d    = load_ovf_q;
    err_idx_d     = err_idx_q;
    got_adr_d     = got_adr_q;
    got_data_d    = got_data_q;
    tbl_we        = 1'b0;
    mismatch      = 1'b0;

    unique case (state_q)
      S_LOAD: begin
        if (start) begin
          state_d = S_RUN;
        end else if (exp_load) begin
          if (count_q == FULL) load_ovf_d = 1'b1;
          else begin
            tbl_we  = 1'b1;
            count_d = count_q + CW'(1);
          end
        end
      end
      S_RUN: begin
        if (cycle_count_q != 16'hFFFF) cycle_count_d = cycle_count_q + 16'd1;
        if (count_q == '0) begin
          pass_d = 1'b1;
        end else if (memwrite) begin
          if (hit) begin
            store_count_d = store_count_q + CW'(1);
            if (store_count_d == count_q) pass_d = 1'b1;
          end else begin
            mismatch   = 1'b1;
            fail_d     = 1'b1;
            err_idx_d  = store_count_q[IW-1:0];
            got_adr_d  = dataadr;
            got_data_d = writedata;
          end
        end
        // A final match on the timeout edge still passes; a mismatch is not a timeout.
        if (!pass_d && !mismatch && cycle_count_q == TO_LAST) begin
          fail_d    = 1'b1;
          timeout_d = 1'b1;
          err_idx_d = store_count_q[IW-1:0];
        end
        if (pass_d)      state_d = S_PASS;
        else if (fail_d) state_d = S_FAIL;
      end
      default: ;
    endcase
    done_d = pass_d | fail_d;
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_LOAD;
      count_q       <= '0;
      store_count_q <= '0;
      cycle_count_q <= '0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      fail_q        <= 1'b0;
      timeout_q     <= 1'b0;
      load_ovf_q    <= 1'b0;
      err_idx_q     <= '0;
      got_adr_q     <= '0;
      got_data_q    <= '0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      store_count_q <= store_count_d;
      cycle_count_q <= cycle_count_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      fail_q        <= fail_d;
      timeout_q     <= timeout_d;
      load_ovf_q    <= load_ovf_d;
      err_idx_q     <= err_idx_d;
      got_adr_q     <= got_adr_d;
      got_data_q    <= got_data_d;
    end
  end

  // NOTE: table storage has no reset; clearing count_q invalidates every entry at once.
  always_ff @(posedge clk) begin
    if (tbl_we) begin
      tbl_adr[count_q[IW-1:0]]  <= exp_adr;
      tbl_data[count_q[IW-1:0]] <= exp_data;
    end
  end

  assign done        = done_q;
  assign pass        = pass_q;
  assign fail        = fail_q;
  assign timeout     = timeout_q;
  assign load_ovf    = load_ovf_q;
  assign err_idx     = err_idx_q;
  assign got_adr     = got_adr_q;
  assign got_data    = got_data_q;
  assign store_count = store_count_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_store_trace_checker.sv
// Scoreboard bench for store_trace_checker: directed scenarios plus randomized traces
// judged by a cycle-walking reference model of the checking rules.
module tb_store_trace_checker;

  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 64;
  localparam int IW      = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst;
  logic          memwrite, exp_load, start;
  logic [31:0]   dataadr, writedata, exp_adr, exp_data;
  logic          done, pass, fail, timeout, load_ovf;
  logic [IW-1:0] err_idx;
  logic [31:0]   got_adr, got_data;
  logic [IW:0]   store_count;
  logic [15:0]   cycle_count;

  store_trace_checker #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(rst), .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
    .exp_load(exp_load), .exp_adr(exp_adr), .exp_data(exp_data), .start(start),
    .done(done), .pass(pass), .fail(fail), .timeout(timeout), .load_ovf(load_ovf),
    .err_idx(err_idx), .got_adr(got_adr), .got_data(got_data),
    .store_count(store_count), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          pass, fail, tmo, ovf, mism;
    int          err_idx, sc, cc;
    logic [31:0] gadr, gdata;
  } outcome_t;

  int          n_checks = 0;
  int          n_pass   = 0;
  outcome_t    sb[$];
  logic [31:0] pa[$], pd[$];          // pushed expected entries
  bit          pw[$];                 // per-RUN-cycle store strobe
  logic [31:0] padr[$], pdat[$];
  bit          seen = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, expv);
  endtask

  // Reference model: walk RUN cycles applying the checking rules directly.
  function automatic outcome_t model();
    outcome_t o;
    int cnt, idx;
    o = '{default: 0};
    o.ovf = (pa.size() > DEPTH);
    cnt = (pa.size() > DEPTH) ? DEPTH : pa.size();
    idx = 0;
    for (int k = 0; k < TIMEOUT; k++) begin
      o.cc = k + 1;
      if (cnt == 0) begin o.pass = 1; break; end
      if (k < pw.size() && pw[k]) begin
        if (padr[k] == pa[idx] && pdat[k] == pd[idx]) begin
          idx++;
          if (idx == cnt) begin o.pass = 1; break; end
        end else begin
          o.fail = 1; o.mism = 1; o.err_idx = idx; o.gadr = padr[k]; o.gdata = pdat[k];
          break;
        end
      end
      if (k == TIMEOUT - 1) begin o.fail = 1; o.tmo = 1; end
    end
    o.sc = idx;
    return o;
  endfunction

  task automatic check_outcome(input string tag, input outcome_t e);
    check({tag, ".done"},        done,        1'b1);
    check({tag, ".pass"},        pass,        e.pass);
    check({tag, ".fail"},        fail,        e.fail);
    check({tag, ".timeout"},     timeout,     e.tmo);
    check({tag, ".load_ovf"},    load_ovf,    e.ovf);
    check({tag, ".store_count"}, store_count, 32'(e.sc));
    check({tag, ".cycle_count"}, cycle_count, 32'(e.cc));
    if (!e.tmo) begin
      check({tag, ".err_idx"},  err_idx,  32'(e.err_idx));
      check({tag, ".got_adr"},  got_adr,  e.gadr);
      check({tag, ".got_data"}, got_data, e.gdata);
    end
  endtask

  // Monitor: pops the expected verdict when done first appears after reset.
  always @(negedge clk) begin
    if (rst) seen = 1'b0;
    else if (done && !seen) begin
      seen = 1'b1;
      if (sb.size() == 0) check("sb_unexpected_done", 32'd1, 32'd0);
      else check_outcome("mon", sb.pop_front());
    end
  end

  task automatic check_idle(input string tag);
    check({tag, ".done"},        done,        1'b0);
    check({tag, ".pass"},        pass,        1'b0);
    check({tag, ".fail"},        fail,        1'b0);
    check({tag, ".timeout"},     timeout,     1'b0);
    check({tag, ".load_ovf"},    load_ovf,    1'b0);
    check({tag, ".err_idx"},     err_idx,     32'd0);
    check({tag, ".got_adr"},     got_adr,     32'd0);
    check({tag, ".got_data"},    got_data,    32'd0);
    check({tag, ".store_count"}, store_count, 32'd0);
    check({tag, ".cycle_count"}, cycle_count, 32'd0);
  endtask

  task automatic idle_inputs();
    memwrite = 0; exp_load = 0; start = 0;
    dataadr = '0; writedata = '0; exp_adr = '0; exp_data = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic clear_scn();
    pa.delete(); pd.delete(); pw.delete(); padr.delete(); pdat.delete();
  endtask

  task automatic add_store(input bit we, input logic [31:0] a, input logic [31:0] d);
    pw.push_back(we); padr.push_back(a); pdat.push_back(d);
  endtask

  // Load pa/pd, start, replay the store plan, then confirm the verdict is frozen.
  task automatic run_scenario(input string tag, input bit collide);
    outcome_t e;
    int k;
    bit timed_out;
    e = model();
    foreach (pa[i]) begin
      @(negedge clk);
      exp_load = 1; exp_adr = pa[i]; exp_data = pd[i];
    end
    @(negedge clk);
    sb.push_back(e);
    start = 1; exp_load = collide; exp_adr = $urandom; exp_data = $urandom;
    k = 0;
    timed_out = 0;
    forever begin
      @(negedge clk);
      start = 0;
      exp_load = 1'($urandom); exp_adr = $urandom; exp_data = $urandom;
      if (done) break;
      if (k > TIMEOUT + 8) begin timed_out = 1; break; end
      memwrite  = (k < pw.size()) ? pw[k] : 1'b0;
      dataadr   = (k < pw.size()) ? padr[k] : 32'd0;
      writedata = (k < pw.size()) ? pdat[k] : 32'd0;
      k++;
    end
    if (timed_out) begin
      check({tag, ".done_within_budget"}, done, 1'b1);
      void'(sb.pop_front());
    end
    repeat (3) begin
      memwrite = 1; dataadr = $urandom; writedata = $urandom; start = 1'($urandom);
      @(negedge clk);
    end
    idle_inputs();
    check_outcome({tag, ".frozen"}, e);
    check({tag, ".sb_drained"}, 32'(sb.size()), 32'd0);
  endtask

  // Random plan: mostly correct in-order stores, occasionally a guaranteed mismatch.
  task automatic gen_plan(input int pfreq);
    int cnt, idx;
    bit we;
    cnt = (pa.size() > DEPTH) ? DEPTH : pa.size();
    idx = 0;
    for (int k = 0; k < TIMEOUT + 4; k++) begin
      we = ($urandom % 100) < pfreq;
      if (!we || idx >= cnt) add_store(1'b0, 32'd0, 32'd0);
      else if (($urandom % 100) < 90) begin
        add_store(1'b1, pa[idx], pd[idx]);
        idx++;
      end else if (k == TIMEOUT - 1) add_store(1'b0, 32'd0, 32'd0);
      else if ($urandom % 2) add_store(1'b1, pa[idx] ^ 32'(1 + $urandom % 7), pd[idx]);
      else add_store(1'b1, pa[idx], pd[idx] ^ 32'(1 + $urandom % 7));
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    do_reset();
    check_idle("reset");

    // Single entry matched on RUN cycle 7.
    clear_scn();
    pa.push_back(32'd255); pd.push_back(32'd251);
    repeat (7) add_store(1'b0, 32'd0, 32'd0);
    add_store(1'b1, 32'd255, 32'd251);
    run_scenario("late_match", 1'b0);

    // Data mismatch on first store.
    do_reset();
    clear_scn();
    pa.push_back(32'd255); pd.push_back(32'd251);
    add_store(1'b1, 32'd255, 32'd250);
    run_scenario("mismatch", 1'b0);

    // One entry, no stores: timeout.
    do_reset();
    clear_scn();
    pa.push_back(32'h40); pd.push_back(32'h1234);
    run_scenario("timeout", 1'b0);

    // 17 pushes overflow; 16 back-to-back matching stores pass.
    do_reset();
    clear_scn();
    for (int i = 0; i < DEPTH + 1; i++) begin
      pa.push_back(32'(i * 4)); pd.push_back($urandom);
    end
    for (int i = 0; i < DEPTH; i++) add_store(1'b1, pa[i], pd[i]);
    run_scenario("overflow", 1'b0);

    // Empty table with a simultaneous mismatching store and a dropped push on start.
    do_reset();
    clear_scn();
    add_store(1'b1, 32'd4, 32'd5);
    run_scenario("empty", 1'b1);

    // Reset mid-RUN after two matched stores.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      exp_load = 1; exp_adr = 32'(i * 8); exp_data = 32'(100 + i);
    end
    @(negedge clk);
    exp_load = 0; start = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      start = 0; memwrite = 1; dataadr = 32'(i * 8); writedata = 32'(100 + i);
    end
    @(negedge clk);
    idle_inputs();
    check("midrun.store_count", store_count, 32'd2);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_idle("midrun_reset");
    @(negedge clk);
    rst = 1'b0;
    clear_scn();
    add_store(1'b1, 32'd0, 32'd100);
    run_scenario("after_midrun", 1'b0);

    // Randomized traces.
    for (int s = 0; s < 40; s++) begin
      do_reset();
      clear_scn();
      for (int i = 0; i < $urandom_range(0, DEPTH + 1); i++) begin
        pa.push_back(32'($urandom_range(0, 15) * 4)); pd.push_back($urandom);
      end
      gen_plan($urandom_range(5, 70));
      run_scenario($sformatf("rnd%0d", s), 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
